// File: rtl/auto_route_n.sv
// Per-channel AND / delay pulse evaluators feeding a merge stage that serialises
// simultaneous fires into one ABO pulse per cycle through a saturating backlog counter.
module auto_route_n #(
    parameter int              N    = 4,
    parameter logic [N-1:0]    MODE = N'(4'b0101),
    parameter int              CW   = 3
) (
    input  logic          TI,
    input  logic          RI,
    input  logic [N-1:0]  AI,
    input  logic [N-1:0]  BI,
    input  logic [N-1:0]  EI,
    output logic          ABO,
    output logic [CW-1:0] PEND,
    output logic          OVF
);

    localparam int             KW  = $clog2(N + 1);
    localparam int             TW  = CW + 6;
    localparam logic [TW-1:0]  CAP = TW'((1 << CW) - 1);

    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  fire_p1_q, fire_p1_d;
    logic          abo_p2_q, abo_p2_d;
    logic [CW-1:0] pend_p2_q, pend_p2_d;
    logic          ovf_p2_q, ovf_p2_d;
    logic [TW-1:0] total;
    logic [TW-1:0] total_m1;

    function automatic logic [KW-1:0] popcount(input logic [N-1:0] v);
        logic [KW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + KW'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [CW-1:0] sat_pend(input logic [TW-1:0] t);
        if (t > CAP) begin
            return CAP[CW-1:0];
        end
        return t[CW-1:0];
    endfunction

    // Stage 0: channel flags; a same-edge strobe survives the evaluate-clear.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        fire_p1_d = '0;
        for (int i = 0; i < N; i++) begin
            if (EI[i]) begin
                fire_p1_d[i] = MODE[i] ? (a_q[i] & b_q[i]) : a_q[i];
                a_d[i]       = AI[i];
                b_d[i]       = MODE[i] & BI[i];
            end else begin
                a_d[i]       = a_q[i] | AI[i];
                b_d[i]       = b_q[i] | (MODE[i] & BI[i]);
            end
        end
    end

    // Stage 1 -> 2: merge registered fires into backlog, emit one pulse per cycle.
    always_comb begin
        total     = TW'(pend_p2_q) + TW'(popcount(fire_p1_q));
        total_m1  = total - TW'(1);
        abo_p2_d  = 1'b0;
        pend_p2_d = pend_p2_q;
        ovf_p2_d  = ovf_p2_q;
        if (total != '0) begin
            abo_p2_d  = 1'b1;
            pend_p2_d = sat_pend(total_m1);
            ovf_p2_d  = ovf_p2_q | (total_m1 > CAP);
        end
    end

    always_ff @(posedge TI) begin
        if (RI) begin
            a_q       <= '0;
            b_q       <= '0;
            fire_p1_q <= '0;
            abo_p2_q  <= 1'b0;
            pend_p2_q <= '0;
            ovf_p2_q  <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            fire_p1_q <= fire_p1_d;
            abo_p2_q  <= abo_p2_d;
            pend_p2_q <= pend_p2_d;
            ovf_p2_q  <= ovf_p2_d;
        end
    end

    assign ABO  = abo_p2_q;
    assign PEND = pend_p2_q;
    assign OVF  = ovf_p2_q;

endmodule

// File: tb/tb_auto_route_n.sv
// Bench for auto_route_n: directed vector table, hand sequences for overflow/reset,
// and random strobes checked against an integer-level reference model (CW=3 and CW=2).
module tb_auto_route_n;

    localparam int          N       = 4;
    localparam logic [3:0]  TB_MODE = 4'b0101;

    logic       TI;
    logic       RI;
    logic [3:0] AI, BI, EI;
    logic       abo3, abo2;
    logic [2:0] pend3;
    logic [1:0] pend2;
    logic       ovf3, ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    auto_route_n #(.N(N), .MODE(TB_MODE), .CW(3)) dut3 (
        .TI(TI), .RI(RI), .AI(AI), .BI(BI), .EI(EI),
        .ABO(abo3), .PEND(pend3), .OVF(ovf3)
    );

    auto_route_n #(.N(N), .MODE(TB_MODE), .CW(2)) dut2 (
        .TI(TI), .RI(RI), .AI(AI), .BI(BI), .EI(EI),
        .ABO(abo2), .PEND(pend2), .OVF(ovf2)
    );

    initial TI = 1'b0;
    always #5 TI = ~TI;

    // Reference model: integer backlog per instance, fire count delayed one edge.
    bit ma[N];
    bit mb[N];
    int mfire;
    int mpend[2];
    bit mabo[2];
    bit movf[2];
    int mcap[2] = '{7, 3};

    task automatic model_edge(input logic [3:0] ai, input logic [3:0] bi,
                              input logic [3:0] ei, input logic ri);
        int nf;
        int tot;
        if (ri) begin
            for (int i = 0; i < N; i++) begin
                ma[i] = 0;
                mb[i] = 0;
            end
            mfire = 0;
            for (int m = 0; m < 2; m++) begin
                mpend[m] = 0;
                mabo[m]  = 0;
                movf[m]  = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                tot = mpend[m] + mfire;
                if (tot > 0) begin
                    mabo[m] = 1;
                    if (tot - 1 > mcap[m]) begin
                        mpend[m] = mcap[m];
                        movf[m]  = 1;
                    end else begin
                        mpend[m] = tot - 1;
                    end
                end else begin
                    mabo[m] = 0;
                end
            end
            nf = 0;
            for (int i = 0; i < N; i++) begin
                if (ei[i]) begin
                    if (TB_MODE[i] ? (ma[i] && mb[i]) : ma[i]) nf++;
                    ma[i] = ai[i];
                    mb[i] = TB_MODE[i] & bi[i];
                end else begin
                    ma[i] = ma[i] | ai[i];
                    mb[i] = mb[i] | (TB_MODE[i] & bi[i]);
                end
            end
            mfire = nf;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] ai, input logic [3:0] bi,
                        input logic [3:0] ei, input logic ri);
        AI = ai;
        BI = bi;
        EI = ei;
        RI = ri;
        @(posedge TI);
        model_edge(ai, bi, ei, ri);
        #1;
        chk("model_abo_cw3",  32'(abo3),  32'(mabo[0]));
        chk("model_pend_cw3", 32'(pend3), 32'(mpend[0]));
        chk("model_ovf_cw3",  32'(ovf3),  32'(movf[0]));
        chk("model_abo_cw2",  32'(abo2),  32'(mabo[1]));
        chk("model_pend_cw2", 32'(pend2), 32'(mpend[1]));
        chk("model_ovf_cw2",  32'(ovf2),  32'(movf[1]));
    endtask

    typedef struct {
        logic [3:0] ai;
        logic [3:0] bi;
        logic [3:0] ei;
        logic       abo;
        logic [2:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] ei,
                                input logic abo, input logic [2:0] pend, input logic ovf);
        vec_t v;
        v.ai = ai; v.bi = bi; v.ei = ei; v.abo = abo; v.pend = pend; v.ovf = ovf;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        AI = '0; BI = '0; EI = '0; RI = 1'b1;

        // Reset with strobes present: they must be ignored.
        step(4'hF, 4'hF, 4'h0, 1'b1);
        step(4'h0, 4'h0, 4'hF, 1'b1);
        chk("rst_abo",  32'(abo3),  32'd0);
        chk("rst_pend", 32'(pend3), 32'd0);
        chk("rst_ovf",  32'(ovf3),  32'd0);

        // AND channel 0 basic fire and repeat-evaluate
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        // AND channel 0: A only then evaluate clears A
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        // A coinciding with evaluate is retained
        tbl.push_back(mk(4'h1, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h1, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        // DFF channel 1
        tbl.push_back(mk(4'h2, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h2, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 4'h2, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h2, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));
        // All four fire at once: four back-to-back pulses
        tbl.push_back(mk(4'hF, 4'hF, 4'h0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'hF, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 3, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 2, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ai, tbl[i].bi, tbl[i].ei, 1'b0);
            chk($sformatf("tbl%0d_abo", i),  32'(abo3),  32'(tbl[i].abo));
            chk($sformatf("tbl%0d_pend", i), 32'(pend3), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_ovf", i),  32'(ovf3),  32'(tbl[i].ovf));
        end

        // Overflow on the CW=2 instance: two bursts of four fires.
        step(4'hF, 4'hF, 4'h0, 1'b0);
        step(4'hF, 4'hF, 4'hF, 1'b0);
        step(4'h0, 4'h0, 4'hF, 1'b0);
        chk("ovf_first_abo",  32'(abo2),  32'd1);
        chk("ovf_first_pend", 32'(pend2), 32'd3);
        chk("ovf_first_ovf",  32'(ovf2),  32'd0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("ovf_sat_pend",   32'(pend2), 32'd3);
        chk("ovf_sat_ovf",    32'(ovf2),  32'd1);
        chk("ovf_cw3_pend",   32'(pend3), 32'd6);
        chk("ovf_cw3_ovf",    32'(ovf3),  32'd0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("ovf_mid_abo",    32'(abo2),  32'd1);
        chk("ovf_mid_pend",   32'(pend2), 32'd2);
        chk("ovf_sticky",     32'(ovf2),  32'd1);

        // Reset mid-backlog, strobes during reset ignored.
        step(4'hF, 4'hF, 4'h0, 1'b1);
        chk("midrst_abo",  32'(abo2),  32'd0);
        chk("midrst_pend", 32'(pend2), 32'd0);
        chk("midrst_ovf",  32'(ovf2),  32'd0);
        chk("midrst_cw3_pend", 32'(pend3), 32'd0);
        step(4'h0, 4'h0, 4'hF, 1'b0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("postrst_noabo_cw2", 32'(abo2), 32'd0);
        chk("postrst_noabo_cw3", 32'(abo3), 32'd0);

        // Random strobes against the model.
        for (int c = 0; c < 400; c++) begin
            logic [3:0] ra, rb, re;
            logic       rr;
            ra = 4'($urandom) & 4'($urandom);
            rb = 4'($urandom) & 4'($urandom);
            re = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rr = ($urandom_range(0, 59) == 0);
            step(ra, rb, re, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_route_n.md
AUTO_ROUTE_N -- requirements
Module: auto_route_n

Interface
REQ-001 Parameter N, default 4: number of input channels (1..16).
REQ-002 Parameter MODE, default 4'b0101 (N bits): per-channel type; bit i = 1 makes channel i a clocked-AND channel, 0 a delay/DFF channel.
REQ-003 Parameter CW, default 3: width of the merge backlog counter (2..8); backlog capacity 2^CW-1.
REQ-004 Port TI, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port RI, input, 1 bit: reset; synchronous and active-high.
REQ-006 Port AI, input, N bits: one-cycle A-pulse strobe per channel.
REQ-007 Port BI, input, N bits: one-cycle B-pulse strobe per channel; ignored on DFF channels.
REQ-008 Port EI, input, N bits: per-channel evaluate/release strobe.
REQ-009 Port ABO, output, 1 bit: merged output pulse, registered, at most one per cycle.
REQ-010 Port PEND, output, CW bits: current merge backlog count, registered.
REQ-011 Port OVF, output, 1 bit: sticky overflow flag, registered.

Function
REQ-012 Each AND channel SHALL hold two flags, a_q and b_q: AI[i] sets a_q and BI[i] sets b_q; repeated strobes while a flag is set have no further effect.
REQ-013 On EI[i], an AND channel SHALL fire f[i] = a_q & b_q, using the registered flags only, and clear both flags in the same edge.
REQ-014 An AI/BI strobe coinciding with EI on the same channel SHALL be excluded from that evaluation and retained, flag set after the clear, for the next evaluation.
REQ-015 Each DFF channel SHALL hold one flag, d_q, set by AI[i]; on EI[i] it SHALL fire f[i] = d_q and clear d_q, with the same-cycle AI rule as REQ-014.
REQ-016 EI[i] with the channel's flags clear SHALL fire nothing and change nothing.
REQ-017 The merge stage SHALL compute k = popcount(f) each cycle and total = PEND + k.
REQ-018 If total > 0, the merge stage SHALL assert ABO for exactly one cycle on the next edge and set PEND_next = total - 1; otherwise ABO_next = 0 and PEND is unchanged.
REQ-019 If total - 1 > 2^CW-1, PEND SHALL saturate at 2^CW-1, excess pulses SHALL be dropped, and OVF SHALL be set.
REQ-020 Latency: a firing EI at edge n with PEND = 0 and no other firing channel SHALL produce ABO = 1 in the cycle after edge n+1, i.e. one registered stage after evaluation.
REQ-021 Simultaneous fires from several channels SHALL emerge as consecutive ABO pulses, one per cycle, with no loss up to capacity; pulse order is indistinguishable and unspecified.
REQ-022 ABO SHALL be high on back-to-back cycles while backlog persists; no gap cycles SHALL be inserted.
REQ-023 OVF SHALL remain set until RI; it has no other effect on operation.
REQ-024 All strobe inputs SHALL be treated as level-sampled each edge; a strobe held high for m cycles counts as m strobes.

Reset
REQ-025 While RI = 1 at an edge, all channel flags, PEND, ABO and OVF SHALL clear to 0, and all AI/BI/EI inputs SHALL be ignored in that cycle.
REQ-026 Reset asserted mid-backlog SHALL discard pending pulses; ABO SHALL be 0 from the first edge after RI is sampled high.
REQ-027 After RI deasserts, the first edge SHALL operate normally with no extra settling cycle.

Verification
REQ-028 AND channel 0: AI[0] at c1, BI[0] at c3, EI[0] at c5 -> ABO = 1 for one cycle after c6 edge, PEND = 0; repeat EI[0] at c7 -> no ABO.
REQ-029 AND channel 0 with only AI[0] set, then EI[0] -> no ABO, a_q cleared; AI[0] and EI[0] together at c1, BI[0] at c2, EI[0] at c3 -> one ABO after c4.
REQ-030 DFF channel 1: AI[1] then EI[1] -> one ABO; BI[1] alone then EI[1] -> none.
REQ-031 N = 4, CW = 3, all four channels primed, EI = 4'b1111 in one cycle -> ABO high for 4 consecutive cycles; PEND reads 3, 2, 1, 0; OVF = 0.
REQ-032 CW = 2, 4 channels primed and fired twice in quick succession so total exceeds 4 -> PEND saturates at 3, excess dropped, OVF = 1 and stays 1 until RI.
REQ-033 RI pulsed while PEND = 2 and ABO = 1 -> next cycle ABO = 0, PEND = 0, OVF = 0, all flags clear; a subsequent EI with no re-priming -> no ABO.
